// File: rtl/ocw3_poll_read_control_if.sv
// ocw3_poll_read_control_if: command strobes, live IRR/ISR/IMR and read/poll results of the OCW3 block.
interface ocw3_poll_read_control_if #(parameter int NUM_IRQ = 8);
  localparam int ID_WIDTH = $clog2(NUM_IRQ);
  logic                write_initial_command_word_1;
  logic                write_operation_control_word_3_registers;
  logic [7:0]          internal_data_bus;
  logic                read_strobe;
  logic                read_imr_select;
  logic [NUM_IRQ-1:0]  interrupt_request_register;
  logic [NUM_IRQ-1:0]  in_service_register;
  logic [NUM_IRQ-1:0]  interrupt_mask;
  logic                special_mask_mode;
  logic                enable_read_register;
  logic                read_register_isr_or_irr;
  logic                poll_active;
  logic                poll_ack;
  logic [ID_WIDTH-1:0] poll_level;
  logic [NUM_IRQ-1:0]  read_data;
  modport slave (
    input  write_initial_command_word_1, write_operation_control_word_3_registers,
           internal_data_bus, read_strobe, read_imr_select,
           interrupt_request_register, in_service_register, interrupt_mask,
    output special_mask_mode, enable_read_register, read_register_isr_or_irr,
           poll_active, poll_ack, poll_level, read_data
  );
  modport master (
    output write_initial_command_word_1, write_operation_control_word_3_registers,
           internal_data_bus, read_strobe, read_imr_select,
           interrupt_request_register, in_service_register, interrupt_mask,
    input  special_mask_mode, enable_read_register, read_register_isr_or_irr,
           poll_active, poll_ack, poll_level, read_data
  );
endinterface

// File: rtl/ocw3_poll_read_control.sv
// ocw3_poll_read_control: OCW3 register-read select, special mask mode and poll command.
// The poll command (D2) exists only when OCW3_POLL_EN is defined.
module ocw3_poll_read_control #(
  parameter int NUM_IRQ = 8
) (
  input logic                      clock,
  input logic                      reset_n,
  ocw3_poll_read_control_if.slave  bus
);
  localparam int ID_WIDTH = $clog2(NUM_IRQ);
  logic       smm_q, smm_d, err_q, err_d, ris_q, ris_d;
  logic       icw1, ocw3;
  logic [7:0] d;
  logic [NUM_IRQ-1:0] reg_data;
  assign icw1 = bus.write_initial_command_word_1;
  assign ocw3 = bus.write_operation_control_word_3_registers;
  assign d    = bus.internal_data_bus;
  always_comb begin
    smm_d = icw1 ? 1'b0 : (ocw3 && d[6]) ? d[5] : smm_q;
    err_d = icw1 ? 1'b1 : (ocw3 && d[1]) ? 1'b1 : err_q;
    ris_d = icw1 ? 1'b0 : (ocw3 && d[1]) ? d[0] : ris_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      smm_q <= 1'b0;
      err_q <= 1'b1;
      ris_q <= 1'b0;
    end else begin
      smm_q <= smm_d;
      err_q <= err_d;
      ris_q <= ris_d;
    end
  end
  assign bus.special_mask_mode        = smm_q;
  assign bus.enable_read_register     = err_q;
  assign bus.read_register_isr_or_irr = ris_q;
  assign reg_data = (bus.read_imr_select || !err_q) ? bus.interrupt_mask :
                    ris_q ? bus.in_service_register : bus.interrupt_request_register;
`ifdef OCW3_POLL_EN
  typedef enum logic {IDLE, ARMED} state_t;
  state_t state_q, state_d;
  logic [NUM_IRQ-1:0]  word_q, word_d, cand, allow, pw;
  logic [ID_WIDTH-1:0] idx;
  logic                ack_q, ack_d, seen;
  // Without special mask, a level is eligible only if no equal-or-higher level is in service.
  always_comb begin
    seen  = 1'b0;
    allow = '0;
    idx   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      seen     = seen | bus.in_service_register[i];
      allow[i] = ~seen | smm_q;
    end
    cand = bus.interrupt_request_register & ~bus.interrupt_mask & allow;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) idx = ID_WIDTH'(i);
    end
    pw                 = '0;
    pw[NUM_IRQ-1]      = |cand;
    pw[ID_WIDTH-1:0]   = idx;
  end
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    ack_d   = 1'b0;
    if (icw1) begin
      state_d = IDLE;
      word_d  = '0;
    end else if (ocw3) begin
      state_d = d[2] ? ARMED : state_q;
      word_d  = d[2] ? pw : word_q;
    end else if (bus.read_strobe && state_q == ARMED) begin
      state_d = IDLE;
      ack_d   = word_q[NUM_IRQ-1];
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      ack_q   <= ack_d;
    end
  end
  assign bus.poll_active = (state_q == ARMED);
  assign bus.poll_ack    = ack_q;
  assign bus.poll_level  = word_q[ID_WIDTH-1:0];
  assign bus.read_data   = (state_q == ARMED) ? word_q : reg_data;
`else
  assign bus.poll_active = 1'b0;
  assign bus.poll_ack    = 1'b0;
  assign bus.poll_level  = '0;
  assign bus.read_data   = reg_data;
`endif
endmodule
